// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage: bus widths, bus layout, load_op bits.
package mem_stage_ctrl_pkg;

  localparam int ES_TO_MS_W = 174;
  localparam int MS_TO_WS_W = 168;
  localparam int MS_FWD_W   = 39;

  // load_op is one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  // Top bit of the csr_data field flags a CSR read whose value is produced in WB
  localparam int CSR_RE_BIT = 33;

  typedef struct packed {
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [33:0] csr_data;
    logic [4:0]  load_op;
    logic        mem_req;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

endpackage

// File: rtl/mem_stage_ctrl_load_extend.sv
// Load data alignment: picks the addressed byte/half and sign- or zero-extends it.
module load_extend
  import mem_stage_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [4:0]  load_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the lane, then extend according to the load type
  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    if (load_op[LD_B])
      result = {{24{byte_sel[7]}}, byte_sel};
    else if (load_op[LD_BU])
      result = {24'd0, byte_sel};
    else if (load_op[LD_H])
      result = {{16{half_sel[15]}}, half_sel};
    else if (load_op[LD_HU])
      result = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: holds one instruction, waits for the data-SRAM response,
// buffers it if WB stalls, drops responses that belong to flushed instructions.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  es_to_ms_valid,
  input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  output logic                  ms_allowin,
  input  logic                  ws_allowin,
  output logic                  ms_to_ws_valid,
  output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  output logic [MS_FWD_W-1:0]   ms_fwd_bus
);

  localparam logic [CANCEL_W-1:0] CNT_ONE = CANCEL_W'(1);

  es_bus_t             es_bus;
  es_bus_t             bus_q, bus_d;
  logic                ms_valid_q, ms_valid_d;
  logic                buf_valid_q, buf_valid_d;
  logic [31:0]         buf_data_q, buf_data_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

  logic        resp_ok, ms_ready_go, ms_leave, is_load, csr_read;
  logic        cnt_inc, cnt_dec, fwd_valid, load_block;
  logic [31:0] load_data, load_result, final_result;

  assign es_bus = es_to_ms_bus;

  // A response only belongs to us once all orphaned ones have drained
  assign resp_ok        = data_sram_data_ok & (cancel_cnt_q == '0);
  assign is_load        = |bus_q.load_op;
  assign ms_ready_go    = ~bus_q.mem_req | buf_valid_q | resp_ok;
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;
  assign ms_leave       = ms_to_ws_valid & ws_allowin;

  assign load_data = buf_valid_q ? buf_data_q : data_sram_rdata;

  load_extend u_load_extend (
    .rdata   (load_data),
    .addr    (bus_q.alu_result[1:0]),
    .load_op (bus_q.load_op),
    .result  (load_result)
  );

  assign final_result = is_load ? load_result : bus_q.alu_result;

  // ID must stall on loads without data yet and on CSR reads resolved later in WB
  assign csr_read   = bus_q.csr_data[CSR_RE_BIT];
  assign fwd_valid  = ms_valid_q & bus_q.gr_we & (bus_q.dest != 5'd0);
  assign load_block = (fwd_valid & is_load & ~(buf_valid_q | resp_ok)) |
                      (ms_valid_q & csr_read);
  assign ms_fwd_bus = {fwd_valid, load_block, bus_q.dest, final_result};

  assign ms_to_ws_bus = {bus_q.rj, bus_q.rkd, bus_q.csr_data, bus_q.gr_we,
                         bus_q.dest, final_result, bus_q.pc};

  // A flushed instruction still waiting on the SRAM leaves one orphan response behind
  assign cnt_inc = flush & ms_valid_q & bus_q.mem_req & ~buf_valid_q & ~resp_ok;
  assign cnt_dec = data_sram_data_ok & (cancel_cnt_q != '0);

  // Next-state logic for valid, bus, response buffer and cancel counter
  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush)
      ms_valid_d = 1'b0;
    else if (ms_allowin)
      ms_valid_d = es_to_ms_valid;

    bus_d = bus_q;
    if (ms_allowin & es_to_ms_valid & ~flush)
      bus_d = es_bus;

    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (flush | ms_leave)
      buf_valid_d = 1'b0;
    else if (resp_ok & ms_valid_q & ~ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end

    case ({cnt_inc, cnt_dec})
      2'b10:   cancel_cnt_d = cancel_cnt_q + CNT_ONE;
      2'b01:   cancel_cnt_d = cancel_cnt_q - CNT_ONE;
      default: cancel_cnt_d = cancel_cnt_q;
    endcase
  end

  // Control state, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      buf_valid_q  <= 1'b0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      buf_valid_q  <= buf_valid_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  // Datapath registers, qualified by the valid bits so they need no reset
  always_ff @(posedge clk) begin
    bus_q      <= bus_d;
    buf_data_q <= buf_data_d;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random traffic against a
// tag-based transaction model of the stage and the data SRAM.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         es_to_ms_valid = 1'b0;
  logic [173:0] es_to_ms_bus = '0;
  logic         ms_allowin;
  logic         ws_allowin = 1'b1;
  logic         ms_to_ws_valid;
  logic [167:0] ms_to_ws_bus;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic [38:0]  ms_fwd_bus;

  mem_stage_ctrl #(.CANCEL_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_fwd_bus        (ms_fwd_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int retired = 0;

  task automatic check_val(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Outstanding SRAM requests in issue order, tagged with the instruction id
  typedef struct {
    int          id;
    int          delay;
    logic [31:0] data;
  } resp_t;
  resp_t resp_q[$];

  // Instruction currently held by MEM
  logic         cur_v = 1'b0;
  int           cur_id = 0;
  int           next_id = 1;
  logic [173:0] cur_bus = '0;
  logic         cur_have = 1'b0;
  logic [31:0]  cur_data = '0;

  logic        e_valid, e_allow, head_cur;
  logic [31:0] e_final;

  function automatic logic [31:0] ext_ref(input logic [31:0] d, input logic [31:0] addr,
                                          input logic [4:0] op);
    logic [31:0] bval, hval;
    bval = (d >> (addr[1:0] * 8)) & 32'hFF;
    hval = (d >> (addr[1] * 16)) & 32'hFFFF;
    case (op)
      5'b10000: return (bval >= 128) ? bval + 32'hFFFF_FF00 : bval;
      5'b01000: return bval;
      5'b00100: return (hval >= 32768) ? hval + 32'hFFFF_0000 : hval;
      5'b00010: return hval;
      5'b00001: return d;
      default:  return addr;
    endcase
  endfunction

  function automatic logic [173:0] mk_bus(input logic csr_re, input logic [4:0] op,
                                          input logic mreq, input logic we,
                                          input logic [4:0] dest, input logic [31:0] alu);
    logic [33:0] csr;
    csr = {2'b00, 32'($urandom)};
    csr[33] = csr_re;
    return {32'($urandom), 32'($urandom), csr, op, mreq, we, dest, alu, 32'($urandom)};
  endfunction

  // Drive one cycle of inputs and check every output against the model
  task automatic drive(input logic f, input logic ev, input logic [173:0] b, input logic wa,
                       input logic dok, input logic [31:0] rd);
    logic        mreq, avail, ready, fv, lb;
    logic [4:0]  op;
    logic [31:0] alu, ldata;
    int          orph;
    @(negedge clk);
    flush = f; es_to_ms_valid = ev; es_to_ms_bus = b; ws_allowin = wa;
    data_sram_data_ok = dok; data_sram_rdata = rd;
    #1;
    head_cur = dok && resp_q.size() > 0 && cur_v && resp_q[0].id == cur_id;
    mreq  = cur_bus[70];
    op    = cur_bus[75:71];
    alu   = cur_bus[63:32];
    avail = cur_have | head_cur;
    ldata = cur_have ? cur_data : rd;
    ready = !mreq || avail;
    e_valid = cur_v && ready && !f;
    e_allow = !cur_v || (ready && wa);
    e_final = (op != 0) ? ext_ref(ldata, alu, op) : alu;
    check_val("ms_to_ws_valid", ms_to_ws_valid, e_valid);
    check_val("ms_allowin", ms_allowin, e_allow);
    if (e_valid)
      check_val("ms_to_ws_bus", ms_to_ws_bus,
                {cur_bus[173:76], cur_bus[69], cur_bus[68:64], e_final, cur_bus[31:0]});
    fv = cur_v && cur_bus[69] && cur_bus[68:64] != 0;
    lb = (fv && op != 0 && !avail) || (cur_v && cur_bus[109]);
    check_val("fwd_valid", ms_fwd_bus[38], fv);
    check_val("load_block", ms_fwd_bus[37], lb);
    if (fv) check_val("fwd_data", ms_fwd_bus[36:0], {cur_bus[68:64], e_final});
    orph = 0;
    foreach (resp_q[i]) if (!(cur_v && resp_q[i].id == cur_id)) orph++;
    check_val("orphans_le_max", (orph <= 3), 1'b1);
    check_val("cancel_cnt", dut.cancel_cnt_q, orph);
  endtask

  // Advance the model across the clock edge using the inputs just driven
  task automatic tick();
    resp_t r;
    @(posedge clk);
    if (e_valid && ws_allowin) begin
      retired++;
      $display("WB id=%0d pc=%h result=%h", cur_id, cur_bus[31:0], e_final);
    end
    if (data_sram_data_ok && resp_q.size() > 0) resp_q.delete(0);
    if (flush) cur_v = 1'b0;
    else if (e_valid && ws_allowin) cur_v = 1'b0;
    else if (head_cur) begin
      cur_have = 1'b1;
      cur_data = data_sram_rdata;
    end
    if (!flush && e_allow && es_to_ms_valid) begin
      cur_v = 1'b1; cur_id = next_id; next_id++;
      cur_bus = es_to_ms_bus; cur_have = 1'b0;
      if (es_to_ms_bus[70]) begin
        r.id = cur_id; r.delay = int'($urandom_range(0, 3)); r.data = $urandom;
        resp_q.push_back(r);
      end
    end
  endtask

  // Reset stage and SRAM together; the model forgets everything
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    cur_v = 1'b0; cur_have = 1'b0;
    resp_q.delete();
  endtask

  logic [173:0] idle_bus = '0;

  initial begin
    logic [173:0] b;
    int r0;

    // reset state
    do_reset();
    drive(0, 0, idle_bus, 1, 0, 0);
    check_val("rst_allowin", ms_allowin, 1'b1);
    check_val("rst_valid", ms_to_ws_valid, 1'b0);
    check_val("rst_fwd_bits", ms_fwd_bus[38:37], 2'b00);
    tick();

    // ALU op passes straight through
    drive(0, 1, mk_bus(0, 5'b0, 0, 1, 5'd5, 32'h1234_5678), 1, 0, 0); tick();
    drive(0, 0, idle_bus, 1, 0, 0);
    check_val("alu_valid", ms_to_ws_valid, 1'b1);
    check_val("alu_result", ms_to_ws_bus[63:32], 32'h1234_5678);
    check_val("alu_fwd_valid", ms_fwd_bus[38], 1'b1);
    tick();

    // ld_b / ld_bu at byte 3, response three cycles after entering MEM
    for (int k = 0; k < 2; k++) begin
      b = mk_bus(0, (k == 0) ? 5'b10000 : 5'b01000, 1, 1, 5'd7, 32'h0000_1003);
      drive(0, 1, b, 1, 0, 0); tick();
      for (int w = 0; w < 2; w++) begin
        drive(0, 0, idle_bus, 1, 0, 32'hDEAD_BEEF);
        check_val("ldb_wait_block", ms_fwd_bus[37], 1'b1);
        tick();
      end
      drive(0, 0, idle_bus, 1, 1, 32'h80FF_1234);
      check_val("ldb_valid", ms_to_ws_valid, 1'b1);
      check_val("ldb_result", ms_to_ws_bus[63:32], (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
    end

    // ld_h at half 1, response while WB is stalled: buffered, issued once
    r0 = retired;
    drive(0, 1, mk_bus(0, 5'b00100, 1, 1, 5'd9, 32'h0000_2002), 1, 0, 0); tick();
    drive(0, 0, idle_bus, 0, 1, 32'h8001_7FFF); tick();
    drive(0, 0, idle_bus, 0, 0, 32'h1111_1111);
    check_val("ldh_buf_valid", dut.buf_valid_q, 1'b1);
    check_val("ldh_hold_result", ms_to_ws_bus[63:32], 32'hFFFF_8001);
    tick();
    drive(0, 0, idle_bus, 1, 0, 32'h2222_2222);
    check_val("ldh_release_result", ms_to_ws_bus[63:32], 32'hFFFF_8001);
    tick();
    drive(0, 0, idle_bus, 1, 0, 0); tick();
    check_val("ldh_issued_once", retired - r0, 1);

    // flush while the load waits: its response becomes an orphan
    drive(0, 1, mk_bus(0, 5'b00001, 1, 1, 5'd3, 32'h40), 1, 0, 0); tick();
    drive(0, 0, idle_bus, 1, 0, 0); tick();
    drive(1, 0, idle_bus, 1, 0, 0);
    check_val("flush_no_valid", ms_to_ws_valid, 1'b0);
    tick();
    drive(0, 0, idle_bus, 1, 0, 0);
    check_val("orphan_cnt_one", dut.cancel_cnt_q, 2'd1);
    tick();
    drive(0, 0, idle_bus, 1, 1, 32'hAAAA_5555);
    check_val("orphan_no_valid", ms_to_ws_valid, 1'b0);
    tick();
    drive(0, 1, mk_bus(0, 5'b00001, 1, 1, 5'd4, 32'h44), 1, 0, 0);
    check_val("orphan_cnt_zero", dut.cancel_cnt_q, 2'd0);
    tick();
    drive(0, 0, idle_bus, 1, 1, 32'hCAFE_F00D);
    check_val("next_load_valid", ms_to_ws_valid, 1'b1);
    check_val("next_load_result", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    tick();

    // flush coinciding with the response: nothing to cancel, output suppressed
    drive(0, 1, mk_bus(0, 5'b00001, 1, 1, 5'd6, 32'h48), 1, 0, 0); tick();
    drive(1, 0, idle_bus, 1, 1, 32'h1234_0000);
    check_val("flush_resp_no_valid", ms_to_ws_valid, 1'b0);
    tick();
    drive(0, 0, idle_bus, 1, 0, 0);
    check_val("flush_resp_cnt", dut.cancel_cnt_q, 2'd0);
    tick();

    // reset with an orphan pending and another load waiting
    drive(0, 1, mk_bus(0, 5'b00001, 1, 1, 5'd8, 32'h50), 1, 0, 0); tick();
    drive(1, 0, idle_bus, 1, 0, 0); tick();
    drive(0, 1, mk_bus(0, 5'b00001, 1, 1, 5'd8, 32'h54), 1, 0, 0); tick();
    check_val("pre_reset_cnt", dut.cancel_cnt_q, 2'd1);
    do_reset();
    drive(0, 0, idle_bus, 1, 0, 0);
    check_val("post_reset_allowin", ms_allowin, 1'b1);
    check_val("post_reset_cnt", dut.cancel_cnt_q, 2'd0);
    check_val("post_reset_buf", dut.buf_valid_q, 1'b0);
    tick();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      logic        dok, mreq, we, csr_re, f;
      logic [31:0] rd;
      logic [4:0]  op, dest;
      int          kind;
      if (resp_q.size() > 0 && resp_q[0].delay == 0) begin
        dok = 1'b1; rd = resp_q[0].data;
      end else begin
        dok = 1'b0; rd = $urandom;
        if (resp_q.size() > 0) resp_q[0].delay--;
      end
      kind = int'($urandom_range(0, 5));
      op = 5'b0; mreq = 1'b0; we = 1'b1; csr_re = 1'b0;
      case (kind)
        0, 1:    csr_re = ($urandom_range(0, 7) == 0);
        2, 3:    begin op = 5'(1 << $urandom_range(0, 4)); mreq = 1'b1; end
        4:       begin mreq = 1'b1; we = 1'b0; end
        default: we = 1'b0;
      endcase
      if (mreq && resp_q.size() >= 3) begin
        mreq = 1'b0; op = 5'b0;
      end
      dest = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      f = ($urandom_range(0, 15) == 0) && resp_q.size() <= 2;
      drive(f, ($urandom_range(0, 3) != 0), mk_bus(csr_re, op, mreq, we, dest, $urandom),
            ($urandom_range(0, 3) != 0), dok, rd);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
